// File: rtl/chroma_upsample_pkg.sv
// Shared types for the chroma upsampler: mode and channel encodings plus FSM state codes.
// Build option UPSAMPLE_ROUND_EN (consumed in upsample_row_calc) selects round-half-up averaging.
package chroma_upsample_pkg;

  typedef enum logic {
    BILINEAR = 1'b0,
    NEAREST  = 1'b1
  } upsample_mode_e;

  typedef enum logic [1:0] {
    CH_Y  = 2'd0,
    CH_CB = 2'd1,
    CH_CR = 2'd2
  } ch_e;

  typedef logic [0:0] state_e;
  localparam state_e IDLE = 1'b0;
  localparam state_e EMIT = 1'b1;

endpackage

// File: rtl/upsample_row_calc.sv
// Purpose: one 2x-upsampled output row from a SRC_DIM x SRC_DIM block (bilinear or replicate).
// Latency: combinational. Backpressure: none. UPSAMPLE_ROUND_EN selects (x+y+1)>>1 averaging.
module upsample_row_calc
  import chroma_upsample_pkg::*;
#(
  parameter int SRC_DIM = 4,
  parameter int PIX_W   = 8,
  localparam int DST_DIM = 2 * SRC_DIM,
  localparam int ROW_W   = $clog2(DST_DIM),
  localparam int SI_W    = $clog2(SRC_DIM)
) (
  input  logic [SRC_DIM-1:0][SRC_DIM-1:0][PIX_W-1:0] blk,
  input  logic [ROW_W-1:0]                           row_idx,
  input  logic                                       mode,
  output logic [DST_DIM-1:0][PIX_W-1:0]              row
);

  function automatic logic [PIX_W-1:0] avg(input logic [PIX_W-1:0] x, input logic [PIX_W-1:0] y);
    logic [PIX_W:0] s;
`ifdef UPSAMPLE_ROUND_EN
    s = {1'b0, x} + {1'b0, y} + {{PIX_W{1'b0}}, 1'b1};
`else
    s = {1'b0, x} + {1'b0, y};
`endif
    return PIX_W'(s >> 1);
  endfunction

  logic [SI_W-1:0] si;
  logic [SI_W-1:0] i1;
  logic            odd_row;

  assign si      = row_idx[ROW_W-1:1];
  assign odd_row = row_idx[0];
  // Bottom edge clamps to the last source row instead of reading past the block.
  assign i1      = (si == SI_W'(SRC_DIM - 1)) ? si : si + SI_W'(1);

  for (genvar j = 0; j < DST_DIM; j++) begin : g_col
    localparam logic [SI_W-1:0] SJ = SI_W'(j / 2);
    localparam logic [SI_W-1:0] J1 = (j / 2 + 1 > SRC_DIM - 1) ? SI_W'(SRC_DIM - 1) : SI_W'(j / 2 + 1);

    logic [PIX_W-1:0] pix_a;
    logic [PIX_W-1:0] pix_c;
    logic [PIX_W-1:0] r1;
    logic [PIX_W-1:0] r2;
    logic [PIX_W-1:0] pix_bil;

    assign pix_a = blk[si][SJ];
    assign pix_c = blk[i1][SJ];

    if (j % 2 == 0) begin : g_even
      assign r1 = pix_a;
      assign r2 = pix_c;
    end else begin : g_odd
      logic [PIX_W-1:0] pix_b;
      logic [PIX_W-1:0] pix_d;
      assign pix_b = blk[si][J1];
      assign pix_d = blk[i1][J1];
      assign r1    = avg(pix_a, pix_b);
      assign r2    = avg(pix_c, pix_d);
    end

    assign pix_bil = odd_row ? avg(r1, r2) : r1;
    assign row[j]  = (mode == 1'(NEAREST)) ? pix_a : pix_bil;
  end

endmodule

// File: rtl/chroma_upsample_stream.sv
// Purpose: accept one Cb/Cr block, stream its 2x-upsampled rows; UPSAMPLE_ROUND_EN picks rounding.
// Latency: row 0 one cycle after accept. Backpressure: rows hold on !out_ready; in_ready tracks last-row handshake.
module chroma_upsample_stream
  import chroma_upsample_pkg::*;
#(
  parameter int SRC_DIM = 4,
  parameter int PIX_W   = 8,
  parameter int CH_W    = 2,
  localparam int DST_DIM = 2 * SRC_DIM,
  localparam int ROW_W   = $clog2(DST_DIM)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [CH_W-1:0]                            in_ch,
  input  logic                                       in_mode,
  input  logic [SRC_DIM-1:0][SRC_DIM-1:0][PIX_W-1:0] in_block,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [DST_DIM-1:0][PIX_W-1:0]              out_row,
  output logic [ROW_W-1:0]                           out_row_idx,
  output logic [CH_W-1:0]                            out_ch,
  output logic                                       out_last,
  output logic                                       drop_pulse
);

  localparam logic [ROW_W-1:0] LAST_IDX = ROW_W'(DST_DIM - 1);

  state_e                                     state_q, state_d;
  logic [SRC_DIM-1:0][SRC_DIM-1:0][PIX_W-1:0] blk_q, blk_d;
  logic                                       mode_q, mode_d;
  logic [DST_DIM-1:0][PIX_W-1:0]              out_row_q, out_row_d;
  logic [ROW_W-1:0]                           row_idx_q, row_idx_d;
  logic [CH_W-1:0]                            out_ch_q, out_ch_d;
  logic                                       out_last_q, out_last_d;
  logic                                       drop_q, drop_d;

  logic                                       accept;
  logic                                       consume;
  logic                                       ch_ok;
  logic [ROW_W-1:0]                           nxt_idx;
  logic [SRC_DIM-1:0][SRC_DIM-1:0][PIX_W-1:0] calc_blk;
  logic [ROW_W-1:0]                           calc_idx;
  logic                                       calc_mode;
  logic [DST_DIM-1:0][PIX_W-1:0]              calc_row;

  assign in_ready = (state_q == IDLE) || ((state_q == EMIT) && out_last_q && out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = (state_q == EMIT) && out_ready;
  assign ch_ok    = (in_ch == CH_W'(CH_CB)) || (in_ch == CH_W'(CH_CR));
  assign nxt_idx  = row_idx_q + ROW_W'(1);

  // On accept, row 0 is computed straight from the input so it can register without a bubble.
  always_comb begin
    calc_blk  = blk_q;
    calc_idx  = nxt_idx;
    calc_mode = mode_q;
    if (accept) begin
      calc_blk  = in_block;
      calc_idx  = '0;
      calc_mode = in_mode;
    end
  end

  upsample_row_calc #(
    .SRC_DIM (SRC_DIM),
    .PIX_W   (PIX_W)
  ) u_row_calc (
    .blk     (calc_blk),
    .row_idx (calc_idx),
    .mode    (calc_mode),
    .row     (calc_row)
  );

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    mode_d     = mode_q;
    out_row_d  = out_row_q;
    row_idx_d  = row_idx_q;
    out_ch_d   = out_ch_q;
    out_last_d = out_last_q;
    drop_d     = 1'b0;
    if (accept) begin
      blk_d  = in_block;
      mode_d = in_mode;
      if (ch_ok) begin
        state_d    = EMIT;
        out_row_d  = calc_row;
        row_idx_d  = '0;
        out_ch_d   = in_ch;
        out_last_d = 1'b0;
      end else begin
        state_d    = IDLE;
        out_last_d = 1'b0;
        drop_d     = 1'b1;
      end
    end else if (consume) begin
      if (out_last_q) begin
        state_d    = IDLE;
        out_last_d = 1'b0;
      end else begin
        out_row_d  = calc_row;
        row_idx_d  = nxt_idx;
        out_last_d = (nxt_idx == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      out_row_q  <= '0;
      row_idx_q  <= '0;
      out_ch_q   <= '0;
      out_last_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      out_row_q  <= out_row_d;
      row_idx_q  <= row_idx_d;
      out_ch_q   <= out_ch_d;
      out_last_q <= out_last_d;
      drop_q     <= drop_d;
    end
  end

  // Block buffer is only read while EMIT, so it needs no reset.
  always_ff @(posedge clk) begin
    blk_q <= blk_d;
  end

  assign out_valid   = (state_q == EMIT);
  assign out_row     = out_row_q;
  assign out_row_idx = row_idx_q;
  assign out_ch      = out_ch_q;
  assign out_last    = out_last_q;
  assign drop_pulse  = drop_q;

endmodule

// File: tb/tb_chroma_upsample_stream.sv
// Bench for chroma_upsample_stream: directed cases plus random blocks against a behavioural row model.
module tb_chroma_upsample_stream;

  localparam int SRC_DIM = 4;
  localparam int PIX_W   = 8;
  localparam int CH_W    = 2;
  localparam int DST_DIM = 2 * SRC_DIM;
  localparam int ROW_W   = $clog2(DST_DIM);
  localparam int RW      = DST_DIM * PIX_W;

  typedef logic [SRC_DIM-1:0][SRC_DIM-1:0][PIX_W-1:0] blk_t;
  typedef logic [DST_DIM-1:0][PIX_W-1:0] row_t;
  typedef struct {
    row_t            row;
    int              idx;
    logic [CH_W-1:0] ch;
    logic            last;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [CH_W-1:0] in_ch;
  logic            in_mode;
  blk_t            in_block;
  logic            out_valid;
  logic            out_ready;
  row_t            out_row;
  logic [ROW_W-1:0] out_row_idx;
  logic [CH_W-1:0] out_ch;
  logic            out_last;
  logic            drop_pulse;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  logic drop_exp = 1'b0;
  logic rnd_bp = 1'b0;
  row_t got_rows [DST_DIM];
  int   lit [DST_DIM];

  chroma_upsample_stream dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ch       (in_ch),
    .in_mode     (in_mode),
    .in_block    (in_block),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .out_ch      (out_ch),
    .out_last    (out_last),
    .drop_pulse  (drop_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic int avg(input int x, input int y);
`ifdef UPSAMPLE_ROUND_EN
    return (x + y + 1) / 2;
`else
    return (x + y) / 2;
`endif
  endfunction

  function automatic int clampi(input int v);
    return (v > SRC_DIM - 1) ? SRC_DIM - 1 : v;
  endfunction

  // Output pixel (i,j): interpolate horizontally on the two nearest source rows, then vertically.
  function automatic row_t model_row(input blk_t b, input int i, input logic m);
    row_t r;
    int si, i1, sj, j1, pa, pb, pc, pd, r1, r2, p;
    si = i / 2;
    i1 = clampi(si + 1);
    for (int j = 0; j < DST_DIM; j++) begin
      sj = j / 2;
      j1 = clampi(sj + 1);
      pa = int'(b[si][sj]);
      pb = int'(b[si][j1]);
      pc = int'(b[i1][sj]);
      pd = int'(b[i1][j1]);
      r1 = (j % 2 == 0) ? pa : avg(pa, pb);
      r2 = (j % 2 == 0) ? pc : avg(pc, pd);
      p  = (i % 2 == 0) ? r1 : avg(r1, r2);
      r[j] = m ? PIX_W'(pa) : PIX_W'(p);
    end
    return r;
  endfunction

  function automatic row_t pack_row(input int v [DST_DIM]);
    row_t r;
    for (int j = 0; j < DST_DIM; j++) r[j] = PIX_W'(v[j]);
    return r;
  endfunction

  // Compare process: outputs against the expected-row queue, then apply this cycle's handshakes.
  always @(negedge clk) begin
    logic exp_rdy;
    exp_t e;
    if (!rst_n) begin
      chk("rst_valid", RW'(out_valid), '0);
      chk("rst_row", RW'(out_row), '0);
      chk("rst_idx_ch_last_drop", RW'({out_row_idx, out_ch, out_last, drop_pulse}), '0);
      exp_q.delete();
      drop_exp = 1'b0;
    end else begin
      exp_rdy = (exp_q.size() == 0) || (exp_q[0].last && out_ready);
      chk("out_valid", RW'(out_valid), RW'(exp_q.size() != 0));
      chk("drop_pulse", RW'(drop_pulse), RW'(drop_exp));
      chk("in_ready", RW'(in_ready), RW'(exp_rdy));
      if (exp_q.size() != 0 && out_valid) begin
        chk("row_data", RW'(out_row), RW'(exp_q[0].row));
        chk("row_idx", RW'(out_row_idx), RW'(exp_q[0].idx));
        chk("row_ch", RW'(out_ch), RW'(exp_q[0].ch));
        chk("row_last", RW'(out_last), RW'(exp_q[0].last));
      end
      drop_exp = 1'b0;
      if (exp_q.size() != 0 && out_valid && out_ready) begin
        got_rows[exp_q[0].idx] = out_row;
        void'(exp_q.pop_front());
      end
      if (in_valid && exp_rdy) begin
        if (in_ch == 2'd1 || in_ch == 2'd2) begin
          for (int i = 0; i < DST_DIM; i++) begin
            e.row  = model_row(in_block, i, in_mode);
            e.idx  = i;
            e.ch   = in_ch;
            e.last = (i == DST_DIM - 1);
            exp_q.push_back(e);
          end
        end else begin
          drop_exp = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_block(input blk_t b, input logic [CH_W-1:0] ch, input logic m);
    int n;
    logic acc;
    in_block = b;
    in_ch    = ch;
    in_mode  = m;
    in_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = in_ready;
      n++;
    end
    if (!acc) timeout("send_block");
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((out_valid || exp_q.size() != 0) && n < 500);
    if (n >= 500) timeout("wait_idle");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_row(input int idx);
    int n;
    n = 0;
    while (!(out_valid && int'(out_row_idx) == idx) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 40) timeout("wait_row");
  endtask

  initial begin
    blk_t b;
    row_t held;
    int   n;
    logic acc;

    rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_mode = 1'b0; in_block = '0; out_ready = 1'b1;
    for (int i = 0; i < DST_DIM; i++) got_rows[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Bilinear on a ramp block, then the same block replicated.
    for (int r = 0; r < SRC_DIM; r++)
      for (int c = 0; c < SRC_DIM; c++)
        b[r][c] = PIX_W'(10 * (c + 1) + 10 * ((r == 0) ? 0 : 1));
    send_block(b, 2'd1, 1'b0);
    wait_idle();
    lit = '{10, 15, 20, 25, 30, 35, 40, 40};
    chk("bil_row0", RW'(got_rows[0]), RW'(pack_row(lit)));
    lit = '{15, 20, 25, 30, 35, 40, 45, 45};
    chk("bil_row1", RW'(got_rows[1]), RW'(pack_row(lit)));

    send_block(b, 2'd2, 1'b1);
    wait_idle();
    lit = '{10, 10, 20, 20, 30, 30, 40, 40};
    chk("near_row0", RW'(got_rows[0]), RW'(pack_row(lit)));
    chk("near_row1", RW'(got_rows[1]), RW'(pack_row(lit)));

    // Rounding corner and full-scale block.
    b = '0;
    b[0][1] = 8'd1;
    send_block(b, 2'd1, 1'b0);
    wait_idle();
`ifdef UPSAMPLE_ROUND_EN
    chk("round_pix01", RW'(got_rows[0][1]), RW'(1));
`else
    chk("round_pix01", RW'(got_rows[0][1]), RW'(0));
`endif
    b = '1;
    send_block(b, 2'd2, 1'b0);
    wait_idle();
    for (int i = 0; i < DST_DIM; i++) chk("sat255_row", RW'(got_rows[i]), RW'({RW{1'b1}}));

    // Backpressure at row 3 for five cycles.
    for (int r = 0; r < SRC_DIM; r++)
      for (int c = 0; c < SRC_DIM; c++) b[r][c] = PIX_W'($urandom_range(0, 255));
    send_block(b, 2'd1, 1'b0);
    wait_row(3);
    out_ready = 1'b0;
    held = out_row;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_hold_row", RW'(out_row), RW'(held));
      chk("bp_hold_idx", RW'(out_row_idx), RW'(3));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("bp_next_idx", RW'(out_row_idx), RW'(4));
    wait_idle();

    // Back-to-back: second block waits for the first block's last-row handshake.
    send_block(b, 2'd1, 1'b0);
    for (int r = 0; r < SRC_DIM; r++)
      for (int c = 0; c < SRC_DIM; c++) b[r][c] = PIX_W'($urandom_range(0, 255));
    in_block = b; in_ch = 2'd2; in_mode = 1'b0; in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        chk("b2b_on_last", RW'({out_valid, out_last, out_ready}), RW'(3'b111));
      end
      n++;
    end
    if (!acc) timeout("b2b_accept");
    chk("b2b_beats", RW'(n), RW'(DST_DIM));
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("b2b_valid", RW'(out_valid), RW'(1));
    chk("b2b_idx0", RW'(out_row_idx), RW'(0));
    chk("b2b_ch", RW'(out_ch), RW'(2));
    wait_idle();

    // Luma block is dropped; then reset in the middle of a Cb block.
    send_block(b, 2'd0, 1'b0);
    chk("drop_hi", RW'({drop_pulse, out_valid}), RW'(2'b10));
    @(posedge clk);
    #1 chk("drop_lo", RW'({drop_pulse, out_valid}), RW'(2'b00));
    send_block(b, 2'd1, 1'b0);
    wait_row(2);
    rst_n = 1'b0;
    #1 chk("rst_mid_valid", RW'(out_valid), RW'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst_idle", RW'({in_ready, out_valid}), RW'(2'b10));

    // Random traffic with random downstream stalls.
    rnd_bp = 1'b1;
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      for (int r = 0; r < SRC_DIM; r++)
        for (int c = 0; c < SRC_DIM; c++)
          b[r][c] = ($urandom_range(0, 7) == 0) ? 8'hff : PIX_W'($urandom_range(0, 255));
      send_block(b, CH_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    rnd_bp = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
